lsu_mem_unit: RTL and testbench

Parametrised load/store unit that replaces the fixed MAR/MDR path and the unfinished lb/lh/lbu/lhu/sb/sh handling of the multicycle RV32I datapath. It accepts one memory request at a time from control/datapath and drives a word-granular memory port with a mem_resp handshake. It generates byte masks, lane-shifts store data, and sign- or zero-extends load data. Misaligned accesses either return an error or are split into two aligned accesses, depending on the optional feature.

---
 rtl/lsu_mem_unit.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_unit.sv
// Load/store unit: byte-lane masks, store lane shifting and load extension over a word-granular memory port.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing misaligned accesses into two aligned accesses.
`timescale 1ns/1ps
module lsu_mem_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic [XLEN-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [XLEN/8-1:0]        mem_wmask,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     mem_resp
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif
  localparam int MW = SPAN * NBYTES;
  localparam int DW = SPAN * XLEN;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
  state_t state;

  logic             we_q;
  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;
  logic [3:0]       sz;
  logic [OFF_W-1:0] off;
  logic             legal, mis, go_err;
  logic [MW-1:0]    lane_mask;
  logic [DW-1:0]    lane_data, merged;
  logic [XLEN-1:0]  ld_word, ld_result;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic             split_q, cross;
  logic [NBYTES-1:0] wmask_hi;
  logic [XLEN-1:0]  wdata_hi, rd_lo;
`endif

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011 && XLEN == 64);
    return (f3 != 3'b111) && ((f3 != 3'b011 && f3 != 3'b110) || XLEN == 64);
  endfunction

  // Sign/zero extension goes through a 64-bit temporary so both XLEN values elaborate.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
    logic [63:0] t;
    case (f3)
      3'b000:  t = {{56{d[7]}},  d[7:0]};
      3'b001:  t = {{48{d[15]}}, d[15:0]};
      3'b010:  t = {{32{d[31]}}, d[31:0]};
      3'b100:  t = {56'd0, d[7:0]};
      3'b101:  t = {48'd0, d[15:0]};
      3'b110:  t = {32'd0, d[31:0]};
      default: t = 64'(d);
    endcase
    return t[XLEN-1:0];
  endfunction

  always_comb begin
    sz        = size_of(req_funct3);
    off       = req_addr[OFF_W-1:0];
    legal     = is_legal(req_we, req_funct3);
    mis       = |(req_addr[3:0] & (sz - 4'd1));
    lane_mask = ((MW'(1) << sz) - MW'(1)) << off;
    lane_data = DW'(req_wdata) << {off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    cross     = (5'(off) + 5'(sz)) > 5'(NBYTES);
    go_err    = !legal;
    merged    = split_q ? {mem_rdata, rd_lo} : DW'(mem_rdata);
`else
    go_err    = !legal || mis;
    merged    = mem_rdata;
`endif
    ld_word   = XLEN'(merged >> {off_q, 3'b000});
    ld_result = extend(ld_word, f3_q);
  end

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wmask   <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q       <= req_we;
          f3_q       <= req_funct3;
          off_q      <= off;
          resp_rdata <= '0;
          if (go_err) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            state       <= ACC1;
            resp_err    <= 1'b0;
            mem_address <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wmask   <= lane_mask[NBYTES-1:0];
            mem_wdata   <= lane_data[XLEN-1:0];
            mem_read    <= !req_we;
            mem_write   <= req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= cross;
            wmask_hi    <= lane_mask[MW-1:NBYTES];
            wdata_hi    <= lane_data[DW-1:XLEN];
`endif
          end
        end
        ACC1: if (mem_resp) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            state       <= ACC2;
            rd_lo       <= mem_rdata;
            mem_address <= mem_address + ADDR_W'(NBYTES);
            mem_wmask   <= wmask_hi;
            mem_wdata   <= wdata_hi;
          end else
`endif
          begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? '0 : ld_result;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        // Strobe drops for one cycle between the two halves, then re-arms.
        ACC2: if (!mem_read && !mem_write) begin
          mem_read  <= !we_q;
          mem_write <= we_q;
        end else if (mem_resp) begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? '0 : ld_result;
        end
`endif
        DONE: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit (XLEN=32); covers the split path when LSU_MISALIGN_SPLIT_EN is defined.
`timescale 1ns/1ps
module tb_lsu_mem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_resp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    tick(); tick();
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_wmask", mem_wmask, 4'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", req_ready, 1'b1);

    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("idle_resp_ignored", resp_valid, 1'b0);
    chk("idle_ready", req_ready, 1'b1);

    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_read_c1", mem_read, 1'b1);
    chk("lb_addr", mem_address, 32'h0000_1000);
    chk("lb_not_ready", req_ready, 1'b0);
    chk("lb_no_write", mem_write, 1'b0);
    tick();
    chk("lb_read_c2", mem_read, 1'b1);
    tick();
    chk("lb_read_c3", mem_read, 1'b1);
    chk("lb_no_resp_yet", resp_valid, 1'b0);
    mem_resp = 1'b1; mem_rdata = 32'h8011_2233;
    tick();
    mem_resp = 1'b0;
    chk("lb_resp_valid", resp_valid, 1'b1);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_err", resp_err, 1'b0);
    chk("lb_read_low", mem_read, 1'b0);
    tick();
    chk("lb_pulse_one", resp_valid, 1'b0);
    chk("lb_ready_again", req_ready, 1'b1);

    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    chk("lhu_addr", mem_address, 32'h0000_2000);
    mem_resp = 1'b1; mem_rdata = 32'hBEEF_1234;
    tick();
    mem_resp = 1'b0;
    chk("lhu_rdata", resp_rdata, 32'h0000_BEEF);
    chk("lhu_err", resp_err, 1'b0);
    tick();

    issue(1'b0, 3'b001, 32'h0000_6002, 32'h0);
    mem_resp = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_resp = 1'b0;
    chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
    tick();

    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
    chk("sb_write", mem_write, 1'b1);
    chk("sb_no_read", mem_read, 1'b0);
    chk("sb_mask", mem_wmask, 4'b0010);
    chk("sb_lane", mem_wdata[15:8], 8'hA5);
    chk("sb_addr", mem_address, 32'h0000_3000);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("sb_resp_valid", resp_valid, 1'b1);
    chk("sb_rdata_zero", resp_rdata, 32'h0);
    chk("sb_write_low", mem_write, 1'b0);
    tick();

    issue(1'b1, 3'b001, 32'h0000_7002, 32'h1234_BEEF);
    chk("sh_mask", mem_wmask, 4'b1100);
    chk("sh_wdata_hi", mem_wdata[31:16], 16'hBEEF);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();

    issue(1'b1, 3'b100, 32'h0000_9000, 32'h0);
    chk("ill_st_valid", resp_valid, 1'b1);
    chk("ill_st_err", resp_err, 1'b1);
    chk("ill_st_no_write", mem_write, 1'b0);
    tick();
    issue(1'b0, 3'b111, 32'h0000_9000, 32'h0);
    chk("ill_ld_err", resp_err, 1'b1);
    chk("ill_ld_no_read", mem_read, 1'b0);
    tick();
    issue(1'b0, 3'b110, 32'h0000_9000, 32'h0);
    chk("lwu_err", resp_err, 1'b1);
    tick();

`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 3'b010, 32'h0000_1002, 32'h0);
    chk("split_rd1", mem_read, 1'b1);
    chk("split_addr1", mem_address, 32'h0000_1000);
    mem_resp = 1'b1; mem_rdata = 32'h4433_2211;
    tick();
    mem_resp = 1'b0;
    chk("split_gap", mem_read, 1'b0);
    chk("split_no_resp", resp_valid, 1'b0);
    tick();
    chk("split_rd2", mem_read, 1'b1);
    chk("split_addr2", mem_address, 32'h0000_1004);
    mem_resp = 1'b1; mem_rdata = 32'h8877_6655;
    tick();
    mem_resp = 1'b0;
    chk("split_valid", resp_valid, 1'b1);
    chk("split_rdata", resp_rdata, 32'h6655_4433);
    chk("split_err", resp_err, 1'b0);
    tick();
    issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hDDCC_BBAA);
    chk("wrap_mask1", mem_wmask, 4'b1100);
    chk("wrap_wdata1", mem_wdata[31:16], 16'hBBAA);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();
    chk("wrap_addr2", mem_address, 32'h0000_0000);
    chk("wrap_mask2", mem_wmask, 4'b0011);
    chk("wrap_wdata2", mem_wdata[15:0], 16'hDDCC);
    chk("wrap_wr2", mem_write, 1'b1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("wrap_done", resp_valid, 1'b1);
    tick();
`else
    issue(1'b1, 3'b010, 32'h0000_4002, 32'h1122_3344);
    chk("mis_sw_valid", resp_valid, 1'b1);
    chk("mis_sw_err", resp_err, 1'b1);
    chk("mis_sw_no_write", mem_write, 1'b0);
    tick();
    chk("mis_sw_no_write2", mem_write, 1'b0);
    chk("mis_sw_pulse", resp_valid, 1'b0);
    issue(1'b0, 3'b001, 32'h0000_8001, 32'h0);
    chk("mis_lh_err", resp_err, 1'b1);
    chk("mis_lh_rdata", resp_rdata, 32'h0);
    chk("mis_lh_no_read", mem_read, 1'b0);
    tick();
`endif

    issue(1'b0, 3'b010, 32'h0000_A004, 32'h0);
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_resp = 1'b0;
    chk("lw_rdata", resp_rdata, 32'hCAFE_F00D);
    chk("lw_err_clear", resp_err, 1'b0);
    tick();

    issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    chk("abort_read_hi", mem_read, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_read_lo", mem_read, 1'b0);
    chk("abort_no_resp", resp_valid, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    mem_resp = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_resp = 1'b0;
    chk("late_resp_ignored", resp_valid, 1'b0);
    chk("late_resp_no_read", mem_read, 1'b0);
    tick();
    chk("late_resp_no_resp2", resp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
